// File: rtl/z80_bridge.sv
// Z80 bus to GPU RAM bridge: synchronises the Z80 strobes, decodes the RAM window
// and turns each bus cycle into one write pulse or one read request with WAIT.
module z80_bridge #(
  parameter logic [21:0] MEM_BASE     = 22'h100000,
  parameter logic [20:0] MEM_SIZE     = 21'h080000,
  parameter int unsigned READ_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        z80_mreq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic [21:0] z80_addr,
  input  logic [7:0]  z80_data_in,
  output logic [7:0]  z80_data_out,
  output logic        z80_data_oe,
  output logic        z80_wait_n,
  output logic        wr_ena,
  output logic        rd_req,
  output logic [19:0] address,
  output logic [7:0]  data_out,
  input  logic        gpu_rd_rdy,
  input  logic [7:0]  data_in,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, WR_END, RD_WAIT, RD_HOLD, BUS_END} state_t;

  // Strobe bit order: {wr_n, rd_n, mreq_n}
  logic [2:0]  strb_meta_q, strb_sync_q;
  logic        mreq_s, rd_s, wr_s;

  state_t      state_q, state_d;
  logic        wr_ena_q, wr_ena_d;
  logic        rd_req_q, rd_req_d;
  logic        timeout_q, timeout_d;
  logic        wait_n_q, wait_n_d;
  logic        oe_q, oe_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [22:0] win_end;
  logic        in_win;
  logic [19:0] offset;

  assign mreq_s  = strb_sync_q[0];
  assign rd_s    = strb_sync_q[1];
  assign wr_s    = strb_sync_q[2];

  assign win_end = {1'b0, MEM_BASE} + {2'b00, MEM_SIZE};
  assign in_win  = ({1'b0, z80_addr} >= {1'b0, MEM_BASE}) && ({1'b0, z80_addr} < win_end);
  assign offset  = z80_addr[19:0] - MEM_BASE[19:0];

  always_comb begin
    state_d   = state_q;
    wr_ena_d  = 1'b0;
    rd_req_d  = 1'b0;
    timeout_d = 1'b0;
    wait_n_d  = wait_n_q;
    oe_d      = oe_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        // MREQ alone (refresh, or strobe not yet synchronised) keeps waiting here.
        if (!mreq_s) begin
          if (!wr_s && rd_s && in_win) begin
            wr_ena_d = 1'b1;
            addr_d   = offset;
            wdata_d  = z80_data_in;
            state_d  = WR_END;
          end else if (!rd_s && wr_s && in_win) begin
            rd_req_d = 1'b1;
            addr_d   = offset;
            wait_n_d = 1'b0;
            cnt_d    = '0;
            state_d  = RD_WAIT;
          end else if (!rd_s || !wr_s) begin
            state_d  = BUS_END;
          end
        end
      end
      WR_END, BUS_END: begin
        if (mreq_s) state_d = IDLE;
      end
      RD_WAIT: begin
        if (gpu_rd_rdy) begin
          rdata_d  = data_in;
          wait_n_d = 1'b1;
          oe_d     = 1'b1;
          state_d  = RD_HOLD;
        end else if (cnt_q == 8'(READ_TIMEOUT - 1)) begin
          rdata_d   = '1;
          wait_n_d  = 1'b1;
          oe_d      = 1'b1;
          timeout_d = 1'b1;
          state_d   = RD_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_HOLD: begin
        if (mreq_s || rd_s) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strb_meta_q <= '1;
      strb_sync_q <= '1;
      state_q     <= IDLE;
      wr_ena_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      timeout_q   <= 1'b0;
      wait_n_q    <= 1'b1;
      oe_q        <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      strb_meta_q <= {z80_wr_n, z80_rd_n, z80_mreq_n};
      strb_sync_q <= strb_meta_q;
      state_q     <= state_d;
      wr_ena_q    <= wr_ena_d;
      rd_req_q    <= rd_req_d;
      timeout_q   <= timeout_d;
      wait_n_q    <= wait_n_d;
      oe_q        <= oe_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign z80_data_out = rdata_q;
  assign z80_data_oe  = oe_q;
  assign z80_wait_n   = wait_n_q;
  assign wr_ena       = wr_ena_q;
  assign rd_req       = rd_req_q;
  assign address      = addr_q;
  assign data_out     = wdata_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_z80_bridge.sv
// Scoreboard bench for z80_bridge: stimulus queues expected bus events, a negedge
// monitor pops and compares every pulse, WAIT release and data-drive it observes.
module tb_z80_bridge;

  localparam logic [2:0] EV_WR = 3'd0, EV_RD = 3'd1, EV_TO = 3'd2, EV_WAIT = 3'd3, EV_OE = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [19:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        z80_mreq_n = 1'b1, z80_rd_n = 1'b1, z80_wr_n = 1'b1;
  logic [21:0] z80_addr = '0;
  logic [7:0]  z80_data_in = '0;
  logic [7:0]  z80_data_out;
  logic        z80_data_oe, z80_wait_n, wr_ena, rd_req, timeout_err;
  logic [19:0] address;
  logic [7:0]  data_out;
  logic        gpu_rd_rdy = 1'b0;
  logic [7:0]  data_in = '0;

  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  z80_bridge #(.MEM_BASE(22'h100000), .MEM_SIZE(21'h080000), .READ_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .z80_mreq_n(z80_mreq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_addr(z80_addr), .z80_data_in(z80_data_in),
    .z80_data_out(z80_data_out), .z80_data_oe(z80_data_oe), .z80_wait_n(z80_wait_n),
    .wr_ena(wr_ena), .rd_req(rd_req), .address(address), .data_out(data_out),
    .gpu_rd_rdy(gpu_rd_rdy), .data_in(data_in), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic ev_t mk(input logic [2:0] k, input logic [19:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    return e;
  endfunction

  // Monitor
  int   wait_len = 0;
  logic prev_wait = 1'b1, prev_oe = 1'b0;

  task automatic observe(input ev_t got);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, none expected", got.kind, got.addr, got.data);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL event: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                 got.kind, got.addr, got.data, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      wait_len  = 0;
      prev_wait = 1'b1;
      prev_oe   = 1'b0;
    end else begin
      if (wr_ena && rd_req) begin
        tests++; fails++;
        $display("FAIL wr_rd_overlap: got both high, expected at most one");
      end
      if (wr_ena)      observe(mk(EV_WR, address, data_out));
      if (rd_req)      observe(mk(EV_RD, address, 8'h00));
      if (timeout_err) observe(mk(EV_TO, 20'h0, 8'h00));
      if (!z80_wait_n) wait_len++;
      else if (!prev_wait) begin
        observe(mk(EV_WAIT, 20'h0, 8'(wait_len)));
        wait_len = 0;
      end
      if (z80_data_oe && !prev_oe) observe(mk(EV_OE, 20'h0, z80_data_out));
      prev_wait = z80_wait_n;
      prev_oe   = z80_data_oe;
    end
  end

  // Stimulus helpers
  task automatic wait_rd_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_req) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL rd_req_timeout: got no rd_req, expected one within 20 clocks");
    end
  endtask

  // Entered at the negedge on which rd_req is seen; d < 0 means the mux never answers.
  task automatic serve_read(input int d, input logic [7:0] rdat, input logic [7:0] exp_out);
    bit ok;
    check("wait_low_at_rd_req", {31'b0, z80_wait_n}, 32'd0);
    if (d >= 0) begin
      repeat (d) @(negedge clk);
      gpu_rd_rdy = 1'b1;
      data_in    = rdat;
      @(negedge clk);
      gpu_rd_rdy = 1'b0;
      data_in    = 8'h00;
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (z80_wait_n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("wait_released", {31'b0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    check("oe_held", {31'b0, z80_data_oe}, 32'd1);
    check("read_data_held", {24'b0, z80_data_out}, {24'b0, exp_out});
    z80_mreq_n = 1'b1;
    z80_rd_n   = 1'b1;
    repeat (6) @(negedge clk);
    check("oe_released", {31'b0, z80_data_oe}, 32'd0);
  endtask

  task automatic do_read(input logic [21:0] a, input int d, input logic [7:0] rdat,
                         input logic [7:0] exp_out, input int exp_len, input bit exp_to);
    bit ok;
    exp_q.push_back(mk(EV_RD, a[19:0] - 20'h00000, 8'h00));
    if (exp_to) exp_q.push_back(mk(EV_TO, 20'h0, 8'h00));
    exp_q.push_back(mk(EV_WAIT, 20'h0, 8'(exp_len)));
    exp_q.push_back(mk(EV_OE, 20'h0, exp_out));
    z80_addr   = a;
    z80_mreq_n = 1'b0;
    z80_rd_n   = 1'b0;
    wait_rd_req(ok);
    if (ok) serve_read(d, rdat, exp_out);
    else begin
      z80_mreq_n = 1'b1; z80_rd_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] wd, input bit exp_pulse,
                          input logic [19:0] exp_addr);
    if (exp_pulse) exp_q.push_back(mk(EV_WR, exp_addr, wd));
    z80_addr    = a;
    z80_data_in = wd;
    z80_mreq_n  = 1'b0;
    z80_wr_n    = 1'b0;
    repeat (8) @(negedge clk);
    check("write_wait_high", {31'b0, z80_wait_n}, 32'd1);
    z80_mreq_n = 1'b1;
    z80_wr_n   = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Bus cycle that must produce nothing: out-of-window read or all strobes low.
  task automatic do_dead_cycle(input logic [21:0] a, input bit with_wr, input string name);
    z80_addr   = a;
    z80_mreq_n = 1'b0;
    z80_rd_n   = 1'b0;
    z80_wr_n   = with_wr ? 1'b0 : 1'b1;
    repeat (8) @(negedge clk);
    check({name, "_wait"}, {31'b0, z80_wait_n}, 32'd1);
    check({name, "_oe"}, {31'b0, z80_data_oe}, 32'd0);
    z80_mreq_n = 1'b1;
    z80_rd_n   = 1'b1;
    z80_wr_n   = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_wait_n", {31'b0, z80_wait_n}, 32'd1);
    check("rst_oe", {31'b0, z80_data_oe}, 32'd0);
    check("rst_pulses", {29'b0, wr_ena, rd_req, timeout_err}, 32'd0);
    check("rst_address", {12'b0, address}, 32'd0);
    check("rst_data_out", {24'b0, data_out}, 32'd0);
    check("rst_z80_data_out", {24'b0, z80_data_out}, 32'd0);

    do_write(22'h100123, 8'h5A, 1'b1, 20'h00123);
    do_write(22'h100000, 8'hA7, 1'b1, 20'h00000);
    do_write(22'h180000, 8'h33, 1'b0, 20'h00000);

    do_read(22'h17FFFF, 3, 8'hC3, 8'hC3, 4, 1'b0);
    do_dead_cycle(22'h0FFFFF, 1'b0, "oow_low");
    do_dead_cycle(22'h180000, 1'b0, "oow_high");

    do_read(22'h100040, -1, 8'h00, 8'hFF, 16, 1'b1);
    do_read(22'h100041, 15, 8'h3C, 8'h3C, 16, 1'b0);

    do_dead_cycle(22'h100050, 1'b1, "all_low");
    gpu_rd_rdy = 1'b1;
    data_in    = 8'h11;
    @(negedge clk);
    gpu_rd_rdy = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(negedge clk);
    check("spurious_rdy_ignored", {24'b0, z80_data_out}, 32'h3C);

    // Reset during RD_WAIT with the bus still held low, then the same read restarts.
    exp_q.push_back(mk(EV_RD, 20'h00077, 8'h00));
    z80_addr   = 22'h100077;
    z80_mreq_n = 1'b0;
    z80_rd_n   = 1'b0;
    wait_rd_req(ok);
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_read_wait", {31'b0, z80_wait_n}, 32'd1);
    check("rst_mid_read_oe", {31'b0, z80_data_oe}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(EV_RD, 20'h00077, 8'h00));
    exp_q.push_back(mk(EV_WAIT, 20'h0, 8'd1));
    exp_q.push_back(mk(EV_OE, 20'h0, 8'h96));
    #2 reset = 1'b0;
    wait_rd_req(ok);
    if (ok) serve_read(0, 8'h96, 8'h96);
    else begin
      z80_mreq_n = 1'b1; z80_rd_n = 1'b1;
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/z80_bridge.md
Z80_BRIDGE -- requirements
Module: z80_bridge

Interface
REQ-001 Parameter MEM_BASE, 22'h100000, first Z80 address of the GPU RAM window.
REQ-002 Parameter MEM_SIZE, 21'h080000, window size in bytes (1..2^20).
REQ-003 Parameter READ_TIMEOUT, 16, max clocks waited for gpu_rd_rdy (2..255).
REQ-004 One clock; reset is asynchronous and active-high: clk input 1, reset input 1.
REQ-005 z80_mreq_n input 1 async Z80 memory request, active low.
REQ-006 z80_rd_n input 1 async Z80 read strobe, active low.
REQ-007 z80_wr_n input 1 async Z80 write strobe, active low.
REQ-008 z80_addr input 22 Z80 banked address.
REQ-009 z80_data_in input 8 Z80 write data.
REQ-010 z80_data_out output 8 read data to Z80 bus.
REQ-011 z80_data_oe output 1 drive enable for z80_data_out.
REQ-012 z80_wait_n output 1 Z80 WAIT, active low.
REQ-013 wr_ena output 1 one-clock write pulse to data mux port.
REQ-014 rd_req output 1 one-clock read request pulse to data mux port.
REQ-015 address output 20 GPU RAM byte address.
REQ-016 data_out output 8 GPU RAM write data.
REQ-017 gpu_rd_rdy input 1 one-clock pulse, data_in valid this clock.
REQ-018 data_in input 8 GPU RAM read data.
REQ-019 timeout_err output 1 one-clock pulse on read timeout.

Function
REQ-020 mreq_n, rd_n, wr_n SHALL pass 2-flop synchronisers; all decisions use synchronised values; z80_addr/z80_data_in sampled on same clock as the decision.
REQ-021 In-window: MEM_BASE <= z80_addr < MEM_BASE+MEM_SIZE; address = z80_addr - MEM_BASE truncated to 20 bits.
REQ-022 FSM states IDLE, WR_END, RD_WAIT, RD_HOLD, BUS_END.
REQ-023 IDLE, mreq low, wr low, rd high, in-window: next clock wr_ena=1 for exactly 1 clock with address/data_out latched; -> WR_END.
REQ-024 IDLE, mreq low, rd low, wr high, in-window: next clock rd_req=1 for 1 clock, address latched, z80_wait_n=0, timeout counter cleared; -> RD_WAIT.
REQ-025 IDLE, mreq low but out-of-window, or rd and wr both low: no output pulse, wait_n stays 1, oe stays 0; -> BUS_END.
REQ-026 RD_WAIT, gpu_rd_rdy=1: z80_data_out <= data_in, z80_wait_n <= 1, z80_data_oe <= 1; -> RD_HOLD.
REQ-027 RD_WAIT, counter reaches READ_TIMEOUT clocks after rd_req without gpu_rd_rdy: z80_data_out <= 8'hFF, wait_n <= 1, oe <= 1, timeout_err 1-clock pulse; -> RD_HOLD.
REQ-028 gpu_rd_rdy arriving on the same clock as timeout SHALL win (real data, no timeout_err).
REQ-029 gpu_rd_rdy outside RD_WAIT SHALL be ignored; data_out register unchanged.
REQ-030 RD_HOLD: oe held 1 and data stable until synchronised mreq_n or rd_n high, then oe <= 0; -> IDLE.
REQ-031 WR_END, BUS_END: -> IDLE when synchronised mreq_n high; no new request accepted before.
REQ-032 Exactly one wr_ena or rd_req pulse per Z80 bus cycle; wr_ena and rd_req never high together.
REQ-033 z80_wait_n SHALL be 0 only in RD_WAIT.

Reset
REQ-034 On reset assertion, asynchronously: state IDLE, wr_ena=0, rd_req=0, timeout_err=0, z80_wait_n=1, z80_data_oe=0, z80_data_out=8'h00, address=0, data_out=0, synchronisers to 1 (inactive), counter 0.
REQ-035 Reset mid-read SHALL release WAIT and bus immediately; after release, a still-low mreq_n is treated as a new cycle only after passing synchronisers.

Verification
REQ-036 Write 8'h5A to z80_addr 22'h100123 -> single wr_ena pulse, address 20'h00123, data_out 8'h5A, wait_n never 0.
REQ-037 Read 22'h17FFFF, mux returns gpu_rd_rdy 3 clocks after rd_req with data_in 8'hC3 -> address 20'h7FFFF, wait_n low until rdy, z80_data_out 8'hC3 with oe=1 until mreq_n high.
REQ-038 Read 22'h0FFFFF and 22'h180000 (out-of-window) -> no rd_req, oe=0, wait_n=1.
REQ-039 Read with no gpu_rd_rdy -> wait_n released after 16 clocks, z80_data_out 8'hFF, one timeout_err pulse; rdy on exactly clock 16 -> real data, no error.
REQ-040 Assert reset during RD_WAIT -> wait_n=1, oe=0 same cycle; next read after release completes normally.
REQ-041 mreq_n, rd_n, wr_n all low -> no pulse; spurious gpu_rd_rdy in IDLE -> z80_data_out unchanged.
